// File: rtl/fact_bus_arbiter.sv
// rtl/fact_bus_arbiter.sv - two-master/two-slave round-robin bus arbiter with hold limit
module fact_bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M0_req,
    input  logic        M1_req,
    input  logic        M0_wr,
    input  logic        M1_wr,
    input  logic [7:0]  M0_address,
    input  logic [7:0]  M1_address,
    input  logic [31:0] M0_dout,
    input  logic [31:0] M1_dout,
    output logic        M0_grant,
    output logic        M1_grant,
    output logic [31:0] M_din,
    output logic        S0_sel,
    output logic        S1_sel,
    output logic        S_wr,
    output logic [7:0]  S_address,
    output logic [31:0] S_din,
    input  logic [31:0] S0_dout,
    input  logic [31:0] S1_dout,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state;
    state_t      state_nxt;
    logic        last;
    logic [7:0]  hold_cnt;
    logic        other_req;
    logic        bus_active;
    logic        unmapped;
    logic [31:0] rd_data;

    assign other_req = (state == GNT0) ? M1_req : M0_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= 8'd0;
            M_din    <= 32'd0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == GNT0)
                last <= 1'b0;
            else if (state == IDLE && state_nxt == GNT1)
                last <= 1'b1;
            // Counter only measures how long the owner has kept the other master waiting
            if (state == IDLE || state_nxt != state)
                hold_cnt <= 8'd0;
            else if (other_req && hold_cnt != 8'hFF)
                hold_cnt <= hold_cnt + 8'd1;
            bus_err <= bus_active && unmapped;
            if (bus_active && !S_wr)
                M_din <= rd_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (M0_req && M1_req)
                    state_nxt = last ? GNT0 : GNT1;
                else if (M0_req)
                    state_nxt = GNT0;
                else if (M1_req)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if (!M0_req || (M1_req && hold_cnt == HOLD_LAST))
                    state_nxt = IDLE;
            end
            GNT1: begin
                if (!M1_req || (M0_req && hold_cnt == HOLD_LAST))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        M0_grant   = (state == GNT0);
        M1_grant   = (state == GNT1);
        bus_active = 1'b0;
        S_wr       = 1'b0;
        S_address  = 8'd0;
        S_din      = 32'd0;
        S0_sel     = 1'b0;
        S1_sel     = 1'b0;
        unmapped   = 1'b0;
        rd_data    = 32'd0;
        // Gating by req lets the bus go quiet in the very cycle a master drops req
        if (state == GNT0 && M0_req) begin
            bus_active = 1'b1;
            S_wr       = M0_wr;
            S_address  = M0_address;
            S_din      = M0_dout;
        end else if (state == GNT1 && M1_req) begin
            bus_active = 1'b1;
            S_wr       = M1_wr;
            S_address  = M1_address;
            S_din      = M1_dout;
        end
        if (bus_active) begin
            if (S_address < 8'h20) begin
                S0_sel  = 1'b1;
                rd_data = S0_dout;
            end else if (S_address < 8'h40) begin
                S1_sel  = 1'b1;
                rd_data = S1_dout;
            end else begin
                unmapped = 1'b1;
            end
        end
    end

endmodule
